// File: rtl/display_scan_ctrl.sv
// Scan scheduler for a 4-digit 7-segment display: scan tick, digit multiplexing, PWM brightness, guard interval, frame-synchronous double buffer.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is never blanked this way).
module display_scan_ctrl #(
  parameter int TICK_DIV    = 10000,
  parameter int BLANK_TICKS = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  sign_in,
  input  logic [3:0]  blank_in,
  input  logic [2:0]  brightness,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        sign,
  output logic        dp_n,
  output logic [3:0]  anodes
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  typedef enum logic {ST_ON, ST_GUARD} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic [2:0]     st, st_nx;
  logic [GW-1:0]  gcnt, gcnt_nx;
  logic [1:0]     sel, sel_nx;
  logic           swap;
  logic [2:0]     bri_q;
  logic           pending;
  logic [15:0]    act_val, shd_val;
  logic [3:0]     act_dp, act_sign, act_blank;
  logic [3:0]     shd_dp, shd_sign, shd_blank;
  logic [3:0]     blank_eff;
  logic           lit;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // NOTE: clocked state is always updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= ST_ON;
      st    <= '0;
      gcnt  <= '0;
      sel   <= '0;
    end else begin
      state <= state_nx;
      st    <= st_nx;
      gcnt  <= gcnt_nx;
      sel   <= sel_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nx = state;
    st_nx    = st;
    gcnt_nx  = gcnt;
    sel_nx   = sel;
    swap     = 1'b0;
    if (tick) begin
      case (state)
        ST_ON: begin
          if (st == 3'd7) begin
            state_nx = ST_GUARD;
            gcnt_nx  = '0;
          end else begin
            st_nx = st + 3'd1;
          end
        end
        ST_GUARD: begin
          if (gcnt == GW'(BLANK_TICKS - 1)) begin
            state_nx = ST_ON;
            st_nx    = '0;
            sel_nx   = sel + 2'd1;
            swap     = (sel == 2'd3);
          end else begin
            gcnt_nx = gcnt + GW'(1);
          end
        end
        default: state_nx = ST_ON;
      endcase
    end
  end

  // Brightness is sampled once per slot, at the end of the slot's first tick.
  always_ff @(posedge CLK) begin
    if (Reset)                                  bri_q <= '0;
    else if (tick && state == ST_ON && st == 3'd0) bri_q <= brightness;
  end

  // NOTE: the shadow set is only consumed while pending is set, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (load) begin
      shd_val   <= value;
      shd_dp    <= dp_in;
      shd_sign  <= sign_in;
      shd_blank <= blank_in;
    end
  end

  // A load on the swap clock leaves pending set: the swap takes the older shadow.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      act_val   <= '0;
      act_dp    <= '0;
      act_sign  <= '0;
      act_blank <= 4'b1111;
      pending   <= 1'b0;
    end else begin
      if (swap && pending) begin
        act_val   <= shd_val;
        act_dp    <= shd_dp;
        act_sign  <= shd_sign;
        act_blank <= shd_blank;
      end
      if (load)      pending <= 1'b1;
      else if (swap) pending <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz;
  always_comb begin
    blank_eff = act_blank;
    lz        = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      lz           = lz & (act_val[4*i +: 4] == 4'h0);
      blank_eff[i] = act_blank[i] | lz;
    end
  end
`else
  assign blank_eff = act_blank;
`endif

  assign lit = (state == ST_ON) && (st <= bri_q) && !blank_eff[sel];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      anodes     <= 4'b1111;
      dp_n       <= 1'b1;
      sign       <= 1'b0;
      digit_sel  <= '0;
      digit_val  <= '0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      anodes     <= lit ? ~(4'b0001 << sel) : 4'b1111;
      dp_n       <= lit ? ~act_dp[sel] : 1'b1;
      sign       <= act_sign[sel];
      digit_sel  <= sel;
      digit_val  <= act_val[{sel, 2'b00} +: 4];
      load_ack   <= swap && pending;
      frame_done <= swap;
    end
  end

endmodule
